adder_stim_gen: RTL and testbench
=================================

ADDER_STIM_GEN -- requirements
Module: adder_stim_gen

Interface
REQ-001 The block SHALL have parameters: LATENCY, default 1, cycles from operand drive to result sample (legal range 1-15).
REQ-002 The block SHALL have parameters: SEED, default 8'hA5, LFSR start value (nonzero).
REQ-003 The block SHALL have parameters: CNT_W, default 8, counter width.
REQ-004 The block SHALL have ports as follows: clk  in  1  single clock; all logic rising-edge.
REQ-005 The block SHALL have ports as follows: reset  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have ports as follows: start  in  1  begin a run; sampled only in IDLE.
REQ-007 The block SHALL have ports as follows: num_vec  in  CNT_W  vectors per run; latched on accepted start.
REQ-008 The block SHALL have ports as follows: valid  out  1  operand strobe to the adder.
REQ-009 The block SHALL have ports as follows: a  out  4  operand A.
REQ-010 The block SHALL have ports as follows: b  out  4  operand B.
REQ-011 The block SHALL have ports as follows: cin  out  1  carry-in.
REQ-012 The block SHALL have ports as follows: c  in  5  adder result {carry, sum[3:0]}.
REQ-013 The block SHALL have ports as follows: busy  out  1  high in DRIVE or WAIT.
REQ-014 The block SHALL have ports as follows: done  out  1  one-cycle end-of-run pulse.
REQ-015 The block SHALL have ports as follows: vec_cnt  out  CNT_W  vectors completed this run.
REQ-016 The block SHALL have ports as follows: err_cnt  out  CNT_W  result mismatches this run.
REQ-017 The block SHALL have ports as follows: mismatch  out  1  sticky, set on any mismatch this run.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, WAIT.
REQ-019 IDLE with start=1 and num_vec!=0 SHALL latch num_vec, reload the LFSR to SEED, clear vec_cnt, err_cnt and mismatch, and go to DRIVE.
REQ-020 IDLE with start=1 and num_vec==0 SHALL pulse done in the next cycle, stay in IDLE, and never assert valid.
REQ-021 DRIVE SHALL last exactly one cycle with valid=1, a=lfsr[3:0], b=lfsr[7:4] and cin=lfsr[7]^lfsr[0], then go to WAIT.
REQ-022 Outside DRIVE, valid SHALL be 0 while a, b and cin hold their last driven values.
REQ-023 WAIT SHALL last exactly LATENCY cycles, and c SHALL be sampled at the rising edge ending the final WAIT cycle.
REQ-024 At that edge the block SHALL increment vec_cnt, advance the LFSR one step (x^8+x^6+x^5+x^4+1, Fibonacci, shift left, feedback into bit 0), and compare c against the 5-bit sum a+b+cin.
REQ-025 After the compare the FSM SHALL go to DRIVE if vec_cnt is less than the latched num_vec; otherwise it SHALL go to IDLE with done=1 for that one cycle.
REQ-026 The vector period SHALL be 1+LATENCY cycles, with back-to-back vectors and no idle gap.
REQ-027 start SHALL be ignored while busy=1, and num_vec changes during a run SHALL have no effect.
REQ-028 vec_cnt and err_cnt SHALL hold their final values in IDLE until the next accepted start.
REQ-029 vec_cnt and err_cnt SHALL saturate at all-ones.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for clk, force state to IDLE, the LFSR to SEED, and valid, a, b, cin, busy, done, vec_cnt, err_cnt and mismatch to 0.
REQ-031 Reset asserted mid-run SHALL abandon the run, produce no done pulse, and leave the next run to replay the identical vector sequence.
REQ-032 Outputs SHALL begin changing on the first rising clk edge after reset deasserts.

Configuration
REQ-033 With macro ADDER_STIM_SCOREBOARD_EN defined, the REQ-024 compare SHALL be compiled in: a mismatch increments err_cnt and sets mismatch.
REQ-034 With ADDER_STIM_SCOREBOARD_EN undefined, the compare logic SHALL be absent, err_cnt and mismatch SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Hold reset=0 with clk running -> all outputs 0 and busy=0; then release reset -> outputs remain 0 until start.
REQ-036 LATENCY=1, num_vec=1, start in cycle 0, ideal adder -> valid=1 in cycle 1 with a=5, b=10, cin=0; done=1 in cycle 3; vec_cnt=1; err_cnt=0; c sampled as 5'h0F.
REQ-037 num_vec=4 with c forced to 0 -> with macro: err_cnt=4 and mismatch=1 at done; without macro: err_cnt=0 and mismatch=0; vec_cnt=4 in both builds.
REQ-038 num_vec=0 with start -> done pulse in the next cycle, valid never 1, busy stays 0.
REQ-039 Assert reset=0 during the second WAIT of a 4-vector run -> outputs 0 immediately and no done; a restarted run again first drives a=5, b=10.
REQ-040 start re-pulsed during DRIVE/WAIT with num_vec changed to 9 -> the run still completes after the original 3 vectors.

Source files
------------

// File: rtl/adder_stim_gen_if.sv
// ---------------------------------------------------------------------------
// adder_stim_gen_if
//
// Operand/result bus between the stimulus generator and the 4-bit adder
// under test.
//
// Signals
//   valid : operand strobe, high for the single cycle a new vector is driven
//   a     : operand A [3:0]
//   b     : operand B [3:0]
//   cin   : carry-in
//   c     : adder result {carry, sum[3:0]}
//
// Modports
//   master : stimulus generator side (drives operands, receives result)
//   slave  : adder side (receives operands, drives result)
// ---------------------------------------------------------------------------
interface adder_stim_gen_if;

    logic       valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] c;

    modport master (
        output valid,
        output a,
        output b,
        output cin,
        input  c
    );

    modport slave (
        input  valid,
        input  a,
        input  b,
        input  cin,
        output c
    );

endinterface

// File: rtl/adder_stim_gen.sv
// ---------------------------------------------------------------------------
// adder_stim_gen
//
// Pseudo-random stimulus generator and checker for a 4-bit adder. Each run
// drives num_vec operand vectors taken from an 8-bit Fibonacci LFSR
// (x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0), waits LATENCY cycles
// per vector for the adder result and counts completed vectors. Vectors are
// back to back with a period of 1+LATENCY cycles.
//
// Optional feature: define ADDER_STIM_SCOREBOARD_EN to compile in the result
// compare (err_cnt / mismatch). Without it both outputs are tied to zero and
// all other behaviour is identical.
//
// Parameters
//   LATENCY : cycles from operand drive to result sample (1..15)
//   SEED    : LFSR start value, must be nonzero
//   CNT_W   : width of num_vec / vec_cnt / err_cnt
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   asynchronous, active-low reset
//   start    in   begin a run (sampled only while idle)
//   num_vec  in   vectors per run, latched on an accepted start
//   bus      --   adder_stim_gen_if.master: valid, a, b, cin out; c in
//   busy     out  high while a run is in progress
//   done     out  one-cycle end-of-run pulse
//   vec_cnt  out  vectors completed this run (saturating)
//   err_cnt  out  result mismatches this run (saturating)
//   mismatch out  sticky, set on any mismatch this run
// ---------------------------------------------------------------------------
module adder_stim_gen #(
    parameter int         LATENCY = 1,
    parameter logic [7:0] SEED    = 8'hA5,
    parameter int         CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_vec,
    adder_stim_gen_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     vec_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 mismatch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Index of the final WAIT cycle; the result is sampled on the edge
    // that ends it.
    localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 1);

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        // Taps at bits 7,5,4,3 realise x^8+x^6+x^5+x^4+1.
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic [7:0]          lfsr_q;
    logic [CNT_W-1:0]    num_q;
    logic [3:0]          wait_q;
    logic                valid_q;
    logic [3:0]          a_q;
    logic [3:0]          b_q;
    logic                cin_q;
    logic                done_q;
    logic [CNT_W-1:0]    vec_q;

    // Control decoded by the next-state process
    logic                accept_run;
    logic                accept_zero;
    logic                sample;
    logic                finish_run;
    logic                load_drive;
    logic [7:0]          drive_word;

    logic [7:0]          lfsr_adv;
    logic [CNT_W-1:0]    vec_inc;
    logic                last_wait;

    assign lfsr_adv  = lfsr_step(lfsr_q);
    assign vec_inc   = sat_inc(vec_q);
    assign last_wait = (wait_q == WAIT_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        accept_run  = 1'b0;
        accept_zero = 1'b0;
        sample      = 1'b0;
        finish_run  = 1'b0;
        load_drive  = 1'b0;
        drive_word  = lfsr_adv;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_vec != '0) begin
                        accept_run = 1'b1;
                        load_drive = 1'b1;
                        drive_word = SEED;
                        state_d    = DRIVE;
                    end else begin
                        // Empty run: report completion without touching
                        // the counters or the operand bus.
                        accept_zero = 1'b1;
                    end
                end
            end

            DRIVE: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (last_wait) begin
                    sample = 1'b1;
                    // vec_inc is the count including the vector just
                    // sampled, so compare it rather than vec_q.
                    if (vec_inc < num_q) begin
                        load_drive = 1'b1;
                        state_d    = DRIVE;
                    end else begin
                        finish_run = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand generation, wait timer and vector counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q  <= SEED;
            num_q   <= '0;
            wait_q  <= '0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            valid_q <= load_drive;
            done_q  <= finish_run | accept_zero;
            wait_q  <= (state_q == WAIT) ? wait_q + 4'd1 : 4'd0;

            if (accept_run) begin
                num_q  <= num_vec;
                vec_q  <= '0;
                lfsr_q <= SEED;
            end else if (sample) begin
                vec_q  <= vec_inc;
                lfsr_q <= lfsr_adv;
            end

            // Operands only change when a new vector is launched, so they
            // hold their last values through WAIT and IDLE.
            if (load_drive) begin
                a_q   <= drive_word[3:0];
                b_q   <= drive_word[7:4];
                cin_q <= drive_word[7] ^ drive_word[0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Result checking
    // -----------------------------------------------------------------------
`ifdef ADDER_STIM_SCOREBOARD_EN
    logic [CNT_W-1:0] err_q;
    logic             mis_q;
    logic [4:0]       sum_exp;

    // Operands are still held at the sampling edge, so the reference sum
    // can be formed directly from the operand registers.
    assign sum_exp = {1'b0, a_q} + {1'b0, b_q} + {4'b0000, cin_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
            mis_q <= 1'b0;
        end else if (accept_run) begin
            err_q <= '0;
            mis_q <= 1'b0;
        end else if (sample && (bus.c != sum_exp)) begin
            err_q <= sat_inc(err_q);
            mis_q <= 1'b1;
        end
    end

    assign err_cnt  = err_q;
    assign mismatch = mis_q;
`else
    // Result bus is not observed in this build.
    logic unused_c;
    assign unused_c = ^bus.c;

    assign err_cnt  = '0;
    assign mismatch = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.valid = valid_q;
    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.cin   = cin_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign vec_cnt   = vec_q;

endmodule

// File: tb/tb_adder_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_adder_stim_gen
//
// Directed bench for adder_stim_gen. A run-level model predicts, from the
// accepted start cycle and the vector count, every output on every cycle;
// the adder is modelled as ideal or as stuck at zero. Literal expectations
// taken from hand computation pin the model's first vectors and timing.
// ---------------------------------------------------------------------------
module tb_adder_stim_gen;

    localparam int         LAT  = 1;
    localparam int         CW   = 8;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int         P    = 1 + LAT;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          start   = 1'b0;
    logic [CW-1:0] num_vec = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] vec_cnt;
    logic [CW-1:0] err_cnt;
    logic          mismatch;
    logic          c_zero  = 1'b0;

    int checks   = 0;
    int failures = 0;

    adder_stim_gen_if bus();

    // Adder stand-in: ideal 4-bit adder or a result stuck at zero.
    assign bus.c = c_zero ? 5'd0
                          : ({1'b0, bus.a} + {1'b0, bus.b} + {4'd0, bus.cin});

    adder_stim_gen #(
        .LATENCY (LAT),
        .SEED    (SEED),
        .CNT_W   (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_vec  (num_vec),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .vec_cnt  (vec_cnt),
        .err_cnt  (err_cnt),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Run-level model
    // -----------------------------------------------------------------------
    int         cyc       = 0;     // cycle index, bumped at every rising edge
    bit         run_valid = 1'b0;  // a nonzero run was accepted since reset
    int         t0        = 0;     // run cycle r = cyc - t0, first drive at r=1
    int         run_n     = 0;
    int         zero_done = -100;  // cycle in which an empty run reports done
    logic [3:0] va [256];
    logic [3:0] vb [256];
    logic       vc [256];
    bit         ve [256];

    function automatic logic [7:0] m_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic bit m_busy(input int c);
        return run_valid && (c - t0) >= 1 && (c - t0) <= run_n * P;
    endfunction

    always @(posedge clk) begin
        logic [7:0] x;
        logic [4:0] s;
        if (reset && start && !m_busy(cyc)) begin
            if (num_vec != 0) begin
                run_valid = 1'b1;
                t0        = cyc;
                run_n     = int'(num_vec);
                x         = SEED;
                for (int k = 0; k < run_n; k++) begin
                    va[k] = x[3:0];
                    vb[k] = x[7:4];
                    vc[k] = x[7] ^ x[0];
                    s     = {1'b0, va[k]} + {1'b0, vb[k]} + {4'd0, vc[k]};
                    ve[k] = ((c_zero ? 5'd0 : s) != s);
                    x     = m_step(x);
                end
            end else begin
                zero_done = cyc + 1;
            end
        end
        cyc++;
    end

    always @(negedge reset) begin
        run_valid = 1'b0;
        zero_done = -100;
    end

    // -----------------------------------------------------------------------
    // Per-cycle compare against the model
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        int         r;
        int         k;
        int         kd;
        logic       e_valid, e_cin, e_busy, e_done, e_mis;
        logic [3:0] e_a, e_b;
        logic [7:0] e_vec, e_err;
        e_valid = 1'b0; e_cin = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_mis   = 1'b0; e_a   = '0;   e_b    = '0;   e_vec  = '0;
        e_err   = '0;
        r = cyc - t0;
        if (run_valid && r >= 1) begin
            k       = (r - 1) / P;
            kd      = (k < run_n) ? k : run_n - 1;
            e_a     = va[kd];
            e_b     = vb[kd];
            e_cin   = vc[kd];
            e_valid = (k < run_n) && ((r - 1) % P == 0);
            e_busy  = (r <= run_n * P);
            e_done  = (r == 1 + run_n * P);
            e_vec   = 8'((k < run_n) ? k : run_n);
`ifdef ADDER_STIM_SCOREBOARD_EN
            for (int j = 0; j < int'(e_vec); j++) if (ve[j]) e_err++;
            e_mis = (e_err != 0);
`endif
        end
        if (cyc == zero_done) e_done = 1'b1;
        check("cycle_outputs",
              {3'd0, bus.valid, bus.a, bus.b, bus.cin, busy, done, vec_cnt, err_cnt, mismatch},
              {3'd0, e_valid, e_a, e_b, e_cin, e_busy, e_done, e_vec, e_err, e_mis});
    end

    // -----------------------------------------------------------------------
    // Directed stimulus
    // -----------------------------------------------------------------------
    task automatic run_start(input logic [CW-1:0] n);
        @(posedge clk); #2;
        start   = 1'b1;
        num_vec = n;
        @(posedge clk); #2;
        start   = 1'b0;
    endtask

    initial begin
        // Reset held with the clock running
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   {31'd0, bus.valid}, 32'd0);
        check("rst_busy",    {31'd0, busy},      32'd0);
        check("rst_ab",      {24'd0, bus.a, bus.b}, 32'd0);
        check("rst_vec_cnt", {24'd0, vec_cnt},   32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {29'd0, bus.valid, busy, done}, 32'd0);

        // Single vector, ideal adder
        run_start(8'd1);
        @(negedge clk);
        check("v0_valid", {31'd0, bus.valid}, 32'd1);
        check("v0_a",     {28'd0, bus.a},     32'd5);
        check("v0_b",     {28'd0, bus.b},     32'd10);
        check("v0_cin",   {31'd0, bus.cin},   32'd0);
        check("v0_c",     {27'd0, bus.c},     32'h0F);
        repeat (2) @(negedge clk);
        check("n1_done",    {31'd0, done},    32'd1);
        check("n1_vec_cnt", {24'd0, vec_cnt}, 32'd1);
        check("n1_err_cnt", {24'd0, err_cnt}, 32'd0);
        repeat (3) @(negedge clk);

        // Four vectors, adder result stuck at zero
        c_zero = 1'b1;
        run_start(8'd4);
        check("model_v1", {20'd0, va[1], vb[1], 3'd0, vc[1]}, {20'd0, 4'd10, 4'd4, 4'd0});
        check("model_v2", {20'd0, va[2], vb[2], 3'd0, vc[2]}, {20'd0, 4'd5, 4'd9, 4'd0});
        @(negedge clk);
        repeat (2) @(negedge clk);
        check("v1_ab", {24'd0, bus.a, bus.b}, {24'd0, 4'd10, 4'd4});
        repeat (6) @(negedge clk);
        check("n4_done",    {31'd0, done},    32'd1);
        check("n4_vec_cnt", {24'd0, vec_cnt}, 32'd4);
`ifdef ADDER_STIM_SCOREBOARD_EN
        check("n4_err_cnt",  {24'd0, err_cnt},  32'd4);
        check("n4_mismatch", {31'd0, mismatch}, 32'd1);
`else
        check("n4_err_cnt",  {24'd0, err_cnt},  32'd0);
        check("n4_mismatch", {31'd0, mismatch}, 32'd0);
`endif
        c_zero = 1'b0;
        repeat (3) @(negedge clk);

        // Empty run
        run_start(8'd0);
        @(negedge clk);
        check("n0_done",  {31'd0, done}, 32'd1);
        check("n0_busy",  {30'd0, busy, bus.valid}, 32'd0);
        @(negedge clk);
        check("n0_done_gone", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);

        // Reset during the second WAIT of a four-vector run
        run_start(8'd4);
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_outs", {20'd0, bus.valid, bus.a, bus.b, bus.cin, busy, done}, 32'd0);
        check("mid_rst_cnt",  {24'd0, vec_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", {31'd0, done}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run_start(8'd4);
        @(negedge clk);
        check("restart_ab", {23'd0, bus.valid, bus.a, bus.b}, {23'd0, 1'b1, 4'd5, 4'd10});
        repeat (8) @(negedge clk);
        check("restart_done", {23'd0, done, vec_cnt}, {23'd0, 1'b1, 8'd4});
        repeat (2) @(negedge clk);

        // start re-pulsed mid-run with a different count
        run_start(8'd3);
        @(posedge clk); #2;
        start   = 1'b1;
        num_vec = 8'd9;
        repeat (2) @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(negedge clk);
        check("repulse_done", {23'd0, done, vec_cnt}, {23'd0, 1'b1, 8'd3});
        @(negedge clk);
        check("repulse_idle", {30'd0, busy, done}, 32'd0);
        num_vec = 8'd0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
